// File: rtl/spi_peripheral_pkg.sv
// rtl/spi_peripheral_pkg.sv - shared types and constants for the SPI register peripheral
package spi_peripheral_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_e;

    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 5;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    // Bit counter stops here so long frames stay distinguishable from exact ones
    localparam logic [4:0] CNT_SAT   = 5'd17;
    localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchronizer with rising/falling edge pulses
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the asynchronous input along the chain; remember last synchronized value
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_in};
        prev_d  = chain_q[STAGES-1];
    end

    // Chain and history flops, reset to the idle level of this SPI line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign d_sync = chain_q[STAGES-1];
    assign rise   = d_sync & ~prev_q;
    assign fall   = ~d_sync & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 write-register peripheral, optional readback via SPI_READBACK_EN
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    // Cycles after reset before the ncs synchronizer reflects the real pin
    localparam logic [7:0] SETTLE_CYCLES = 8'(SYNC_STAGES + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s,  ncs_rise,  ncs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_in(sclk),
        .d_sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_in(copi),
        .d_sync(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_in(ncs),
        .d_sync(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_s, copi_rise, copi_fall, sclk_fall};

    spi_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];
    logic [7:0]  settle_q, settle_d;
    logic        armed_q, armed_d;
    logic [6:0]  wr_addr;
    logic        wr_en;

    assign wr_addr = shift_q[14:8];
    assign wr_en   = shift_q[15] && (wr_addr <= MAX_ADDR);

    // Only accept an ncs falling edge once ncs has been seen high after reset,
    // so a chip select held low across reset cannot start a bogus frame
    always_comb begin
        settle_d = settle_q;
        armed_d  = armed_q;
        if (settle_q != SETTLE_CYCLES) begin
            settle_d = settle_q + 8'd1;
        end else if (ncs_s) begin
            armed_d = 1'b1;
        end
    end

    // Frame FSM: collect bits while selected, commit only exact 16-bit frames
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall && armed_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 5'd0;
                    shift_d = 16'h0000;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = (cnt_q == CNT_FRAME) ? ST_COMMIT : ST_IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (wr_en) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_addr == 7'(i)) begin
                            regs_d[i] = shift_q[7:0];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame state and register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            shift_q  <= 16'h0000;
            settle_q <= 8'd0;
            armed_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            settle_q <= settle_d;
            armed_q  <= armed_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0[2:0]];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8[2:0]];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0[2:0]];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8[2:0]];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY[2:0]];

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       cipo_q, cipo_d;
    logic       rd_q, rd_d;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    // Address is complete on the 8th rising edge: 6 bits held plus the incoming one
    assign rd_addr = {shift_q[5:0], copi_s};

    // Register selected by the incoming read address, zero when out of range
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((rd_addr == 7'(i)) && (rd_addr <= MAX_ADDR)) begin
                rd_data = regs_q[i];
            end
        end
    end

    // Transmit path: load after the address byte; MSB must be valid for the 9th
    // rising edge, so shifting starts on the falling edge after that one
    always_comb begin
        tx_d   = tx_q;
        cipo_d = cipo_q;
        rd_d   = rd_q;
        if ((state_q != ST_SHIFT) || ncs_rise) begin
            tx_d   = 8'h00;
            cipo_d = 1'b0;
            rd_d   = 1'b0;
        end else if (sclk_rise && (cnt_q == 5'd7) && !shift_q[6]) begin
            rd_d   = 1'b1;
            tx_d   = rd_data;
            cipo_d = rd_data[7];
        end else if (sclk_fall && rd_q && (cnt_q >= 5'd9)) begin
            tx_d   = {tx_q[6:0], 1'b0};
            cipo_d = tx_q[6];
        end
    end

    // Transmit shift register and registered cipo
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q   <= 8'h00;
            cipo_q <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            cipo_q <= cipo_d;
            rd_q   <= rd_d;
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - self-checking bench for spi_peripheral with behavioural register model
module tb_spi_peripheral;
    import spi_peripheral_pkg::*;

    localparam int S    = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       cipo;
    logic [7:0] o0, o1, o2, o3, o4;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  model [5];
    logic [15:0] smp;
    logic [15:0] exp_cipo;

    always #5 clk = ~clk;

    spi_peripheral #(.SYNC_STAGES(S), .MAX_ADDR(7'h04)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(o0), .en_reg_out_15_8(o1), .en_reg_pwm_7_0(o2),
        .en_reg_pwm_15_8(o3), .pwm_duty_cycle(o4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ":r0"}, {24'h0, o0}, {24'h0, model[0]});
        check({tag, ":r1"}, {24'h0, o1}, {24'h0, model[1]});
        check({tag, ":r2"}, {24'h0, o2}, {24'h0, model[2]});
        check({tag, ":r3"}, {24'h0, o3}, {24'h0, model[3]});
        check({tag, ":r4"}, {24'h0, o4}, {24'h0, model[4]});
    endtask

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        logic [2:0] idx;
        idx = a[2:0];
        return (a <= 7'd4) ? model[idx] : 8'h00;
    endfunction

    // Register effect of a frame: only exact 16-bit writes to addr 0..4 land
    task automatic model_apply(input logic [15:0] w, input int nbits);
        logic [2:0] idx;
        idx = w[10:8];
        if (nbits == 16 && w[15] && w[14:8] <= 7'd4) model[idx] = w[7:0];
    endtask

    // Expected cipo seen just before each rising edge of a 16-bit frame
    function automatic logic [15:0] model_cipo(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
`ifdef SPI_READBACK_EN
        if (!w[15]) r = {8'h00, model_rd(w[14:8])};
`endif
        return r;
    endfunction

    // Select, clock out nbits MSB first (extra bits are 0), leave ncs low
    task automatic frame_body(input logic [15:0] w, input int nbits, output logic [15:0] s);
        s = 16'h0000;
        ncs = 1'b0;
        waitc(HALF);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15-i] : 1'b0;
            waitc(HALF);
            if (i < 16) s[15-i] = cipo;
            sclk = 1'b1;
            waitc(HALF);
            sclk = 1'b0;
        end
        waitc(HALF);
    endtask

    task automatic send(input logic [15:0] w, input int nbits, output logic [15:0] s);
        frame_body(w, nbits, s);
        ncs = 1'b1;
        waitc(12);
        model_apply(w, nbits);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        waitc(4);
        check_regs("reset");
        check("reset:cipo", {31'h0, cipo}, 32'h0);
        check("reset:state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
        rst_n = 1'b1;
        waitc(10);

        // Single write to address 0
        send(16'h80F0, 16, smp);
        check_regs("w80F0");
        check("w80F0:cipo", {16'h0, smp}, 32'h0);

        // Write latency measured from the raw ncs rising edge
        frame_body(16'h8101, 16, smp);
        ncs = 1'b1;
        repeat (S + 1) @(posedge clk);
        #1 check("lat:early", {24'h0, o1}, 32'h00);
        @(posedge clk);
        #1 check("lat:exact", {24'h0, o1}, 32'h01);
        waitc(12);
        model_apply(16'h8101, 16);

        send(16'h8202, 16, smp);
        send(16'h8303, 16, smp);
        send(16'h8480, 16, smp);
        check_regs("w01-04");

        // Out-of-range write, then read frame (readback of reg 4)
        send(16'h85AA, 16, smp);
        check_regs("w85AA");
        check("w85AA:state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
        exp_cipo = model_cipo(16'h0400);
        send(16'h0400, 16, smp);
        check_regs("r0400");
        check("r0400:state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
        check("r0400:cipo", {16'h0, smp}, {16'h0, exp_cipo});

        // Short and long frames are discarded
        send(16'h80FF, 15, smp);
        check_regs("short15");
        send(16'h80FF, 17, smp);
        check_regs("long17");

        // Readback of a freshly written value
        send(16'h8233, 16, smp);
        exp_cipo = model_cipo(16'h0200);
        send(16'h0200, 16, smp);
        check("r0200:cipo", {16'h0, smp}, {16'h0, exp_cipo});
        check("r0200:cipo_idle", {31'h0, cipo}, 32'h0);

        // Reset in the middle of a frame, ncs held low across it
        ncs = 1'b0;
        waitc(HALF);
        for (int i = 0; i < 9; i++) begin
            copi = (16'h8455 >> (15 - i)) & 16'h1;
            waitc(HALF);
            sclk = 1'b1;
            waitc(HALF);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        waitc(3);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        check_regs("midrst");
        check("midrst:cipo", {31'h0, cipo}, 32'h0);
        waitc(10);
        check("midrst:state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
        ncs = 1'b1;
        waitc(12);
        send(16'h8455, 16, smp);
        check_regs("after_rst");

        // Randomized frames against the model
        for (int k = 0; k < 24; k++) begin
            logic [15:0] w;
            int          nb;
            int          r;
            w  = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            r  = $urandom_range(0, 9);
            nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            exp_cipo = model_cipo(w);
            send(w, nb, smp);
            check_regs($sformatf("rnd%0d_%h_%0d", k, w, nb));
            if (nb == 16) check($sformatf("rnd%0d:cipo", k), {16'h0, smp}, {16'h0, exp_cipo});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
